// File: rtl/mouse_pos_tracker_pkg.sv
// Shared types and defaults for the PS/2 mouse position tracker:
// packet-assembly states, screen limits and the header/delta helpers.
package mouse_pos_tracker_pkg;

   localparam int POS_W   = 12;
   localparam int DELTA_W = 13;

   localparam int unsigned SCREEN_X_MAX    = 1023;
   localparam int unsigned SCREEN_Y_MAX    = 767;
   localparam int unsigned SCREEN_X_INIT   = 512;
   localparam int unsigned SCREEN_Y_INIT   = 384;
   localparam int unsigned DEFAULT_TIMEOUT = 65_000_000;

   typedef enum logic [2:0] {
      BYTE0 = 3'b001,
      BYTE1 = 3'b010,
      BYTE2 = 3'b100
   } state_e;

   // Only the header fields the tracker consumes are kept.
   typedef struct packed {
      logic y_ovf;
      logic x_ovf;
      logic y_sign;
      logic x_sign;
      logic right;
      logic left;
   } hdr_t;

   function automatic logic signed [DELTA_W-1:0] axis_delta(input logic sgn,
                                                           input logic [7:0] low,
                                                           input logic ovf);
      logic signed [DELTA_W-1:0] d;
      if (ovf) begin
         d = 13'sd0;
      end else begin
         d = $signed({{5{sgn}}, sgn, low});
      end
      return d;
   endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: position plus signed delta, clamped into 0..max.
module mouse_axis_accum
   import mouse_pos_tracker_pkg::*;
(
   input  logic [POS_W-1:0]          pos_i,
   input  logic signed [DELTA_W-1:0] delta_i,
   input  logic [POS_W-1:0]          max_i,
   output logic [POS_W-1:0]          pos_o
);

   logic signed [POS_W+1:0] sum_s;
   logic signed [POS_W+1:0] max_s;

   always_comb begin
      sum_s = $signed({2'b00, pos_i}) + (POS_W+2)'(delta_i);
      max_s = $signed({2'b00, max_i});
      if (sum_s < 14'sd0) begin
         pos_o = {POS_W{1'b0}};
      end else if (sum_s > max_s) begin
         pos_o = max_i;
      end else begin
         pos_o = sum_s[POS_W-1:0];
      end
   end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets and keeps a clamped cursor position
// plus button state; a stalled partial packet is dropped after TIMEOUT cycles.
module mouse_pos_tracker
   import mouse_pos_tracker_pkg::*;
#(
   parameter int unsigned X_MAX   = SCREEN_X_MAX,
   parameter int unsigned Y_MAX   = SCREEN_Y_MAX,
   parameter int unsigned X_INIT  = SCREEN_X_INIT,
   parameter int unsigned Y_INIT  = SCREEN_Y_INIT,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [11:0] mouse_xpos,
   output logic [11:0] mouse_ypos,
   output logic        mouse_left,
   output logic        mouse_right,
   output logic        pos_update
);

   localparam logic [POS_W-1:0] X_MAX_C   = POS_W'(X_MAX);
   localparam logic [POS_W-1:0] Y_MAX_C   = POS_W'(Y_MAX);
   localparam logic [31:0]      TO_LAST_C = 32'(TIMEOUT - 1);

   state_e            state_q, state_d;
   hdr_t              hdr_q, hdr_d;
   logic [7:0]        b1_q, b1_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              apply_s;
   logic [POS_W-1:0]  xpos_q, ypos_q, xnew_s, ynew_s;
   logic              left_q, right_q, upd_q;
   logic signed [DELTA_W-1:0] dx_s, dy_s, dy_neg_s;

   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      b1_d    = b1_q;
      cnt_d   = cnt_q;
      apply_s = 1'b0;
      if (rx_valid) begin
         cnt_d = 32'd0;
         case (state_q)
            BYTE0: begin
               if (rx_data[3]) begin
                  hdr_d   = {rx_data[7:4], rx_data[1:0]};
                  state_d = BYTE1;
               end else begin
                  state_d = BYTE0;
               end
            end
            BYTE1: begin
               b1_d    = rx_data;
               state_d = BYTE2;
            end
            BYTE2: begin
               apply_s = 1'b1;
               state_d = BYTE0;
            end
            default: state_d = BYTE0;
         endcase
      end else if (state_q != BYTE0) begin
         // Idle mid-packet: give up on the packet once TIMEOUT idle cycles pass.
         if (cnt_q == TO_LAST_C) begin
            cnt_d   = 32'd0;
            state_d = BYTE0;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign dx_s     = axis_delta(hdr_q.x_sign, b1_q, hdr_q.x_ovf);
   assign dy_s     = axis_delta(hdr_q.y_sign, rx_data, hdr_q.y_ovf);
   assign dy_neg_s = 13'sd0 - dy_s;

   mouse_axis_accum u_x_accum (
      .pos_i   (xpos_q),
      .delta_i (dx_s),
      .max_i   (X_MAX_C),
      .pos_o   (xnew_s)
   );

   // Screen Y grows downward, so the PS/2 (up-positive) delta is subtracted.
   mouse_axis_accum u_y_accum (
      .pos_i   (ypos_q),
      .delta_i (dy_neg_s),
      .max_i   (Y_MAX_C),
      .pos_o   (ynew_s)
   );

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q <= BYTE0;
         hdr_q   <= '0;
         b1_q    <= 8'd0;
         cnt_q   <= 32'd0;
         xpos_q  <= POS_W'(X_INIT);
         ypos_q  <= POS_W'(Y_INIT);
         left_q  <= 1'b0;
         right_q <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         b1_q    <= b1_d;
         cnt_q   <= cnt_d;
         upd_q   <= apply_s;
         if (apply_s) begin
            xpos_q  <= xnew_s;
            ypos_q  <= ynew_s;
            left_q  <= hdr_q.left;
            right_q <= hdr_q.right;
         end
      end
   end

   assign mouse_xpos  = xpos_q;
   assign mouse_ypos  = ypos_q;
   assign mouse_left  = left_q;
   assign mouse_right = right_q;
   assign pos_update  = upd_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Randomised and directed bench for mouse_pos_tracker with a queue-based
// packet reference model and a scoreboard monitor on pos_update.
module tb_mouse_pos_tracker;

   localparam int TO = 40;

   logic        pclk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [11:0] mouse_xpos, mouse_ypos;
   logic        mouse_left, mouse_right, pos_update;

   mouse_pos_tracker #(.TIMEOUT(TO)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .mouse_xpos  (mouse_xpos),
      .mouse_ypos  (mouse_ypos),
      .mouse_left  (mouse_left),
      .mouse_right (mouse_right),
      .pos_update  (pos_update)
   );

   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_n = 0;
   int n_pulses = 0;

   always @(posedge pclk) edge_n <= edge_n + 1;

   typedef struct {
      int x;
      int y;
      int l;
      int r;
      int stamp;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_x, m_y, m_l, m_r;
   int idle;
   bit [7:0] pkt[$];

   function automatic int delta9(bit s, bit [7:0] low, bit ovf);
      if (ovf) return 0;
      return s ? int'(low) - 256 : int'(low);
   endfunction

   function automatic int clampi(int v, int mx);
      if (v < 0) return 0;
      if (v > mx) return mx;
      return v;
   endfunction

   task automatic model_reset();
      m_x = 512; m_y = 384; m_l = 0; m_r = 0;
      idle = 0;
      pkt.delete();
   endtask

   task automatic model_step(input bit v, input bit [7:0] d, input int stamp);
      bit [7:0] h;
      exp_t e;
      if (v) begin
         idle = 0;
         if (pkt.size() == 0 && !d[3]) return;
         pkt.push_back(d);
         if (pkt.size() == 3) begin
            h   = pkt[0];
            m_x = clampi(m_x + delta9(h[4], pkt[1], h[6]), 1023);
            m_y = clampi(m_y - delta9(h[5], pkt[2], h[7]), 767);
            m_l = int'(h[0]);
            m_r = int'(h[1]);
            e = '{x: m_x, y: m_y, l: m_l, r: m_r, stamp: stamp};
            sbq.push_back(e);
            pkt.delete();
         end
      end else if (pkt.size() != 0) begin
         idle++;
         if (idle >= TO) begin
            pkt.delete();
            idle = 0;
         end
      end
   endtask

   // ---------------- monitor ----------------
   int hx = 512, hy = 384, hl = 0, hr = 0;

   always @(negedge pclk) begin
      if (rst) begin
         hx = 512; hy = 384; hl = 0; hr = 0;
      end else if (pos_update) begin
         n_pulses++;
         if (sbq.size() == 0) begin
            chk("spurious_pos_update", int'(pos_update), 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("update_cycle", edge_n, e.stamp);
            chk("xpos", int'(mouse_xpos), e.x);
            chk("ypos", int'(mouse_ypos), e.y);
            chk("left", int'(mouse_left), e.l);
            chk("right", int'(mouse_right), e.r);
            hx = e.x; hy = e.y; hl = e.l; hr = e.r;
         end
      end else begin
         if (sbq.size() != 0 && sbq[0].stamp <= edge_n) begin
            chk("pos_update_missing", int'(pos_update), 1);
            void'(sbq.pop_front());
         end
         chk("hold_xpos", int'(mouse_xpos), hx);
         chk("hold_ypos", int'(mouse_ypos), hy);
         chk("hold_buttons", int'({mouse_left, mouse_right}), (hl * 2) + hr);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit v, input bit [7:0] d);
      rx_valid = v;
      rx_data  = d;
      model_step(v, d, edge_n + 1);
      @(posedge pclk);
      #1;
   endtask

   task automatic pkt3(input bit [7:0] a, input bit [7:0] b, input bit [7:0] c);
      cyc(1'b1, a);
      cyc(1'b1, b);
      cyc(1'b1, c);
      cyc(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      rst = 1'b1;
      model_reset();
      sbq.delete();
      #2;
      chk("rst_xpos", int'(mouse_xpos), 512);
      chk("rst_ypos", int'(mouse_ypos), 384);
      chk("rst_left", int'(mouse_left), 0);
      chk("rst_right", int'(mouse_right), 0);
      chk("rst_pos_update", int'(pos_update), 0);
      @(posedge pclk);
      #1;
      rst = 1'b0;
      @(posedge pclk);
      #1;
   endtask

   task automatic expect_now(input string name, input int x, input int y);
      chk({name, "_x"}, int'(mouse_xpos), x);
      chk({name, "_y"}, int'(mouse_ypos), y);
   endtask

   initial begin
      int p0;
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      model_reset();
      @(posedge pclk);
      #1;
      do_reset();

      // basic packet with left button
      p0 = n_pulses;
      pkt3(8'h09, 8'h10, 8'h20);
      expect_now("basic", 528, 352);
      chk("basic_left", int'(mouse_left), 1);
      chk("basic_pulses", n_pulses - p0, 1);

      // negative deltas, Y clamps at bottom
      do_reset();
      for (int i = 0; i < 3; i++) pkt3(8'h38, 8'h80, 8'h80);
      expect_now("neg3", 128, 767);

      // walk X to 1000, clamp high, then overflow packet
      do_reset();
      pkt3(8'h08, 8'hFF, 8'h00);
      pkt3(8'h08, 8'hE9, 8'h00);
      expect_now("walk", 1000, 384);
      pkt3(8'h08, 8'h7F, 8'h00);
      expect_now("clamp_hi", 1023, 384);
      pkt3(8'h48, 8'h7F, 8'h00);
      expect_now("x_ovf", 1023, 384);

      // resync: non-header byte dropped
      do_reset();
      cyc(1'b1, 8'h00);
      pkt3(8'h09, 8'h05, 8'h05);
      expect_now("resync", 517, 379);

      // timeout discards a partial packet
      do_reset();
      p0 = n_pulses;
      cyc(1'b1, 8'h08);
      cyc(1'b1, 8'h10);
      for (int i = 0; i < TO; i++) cyc(1'b0, 8'h00);
      pkt3(8'h08, 8'h01, 8'h00);
      expect_now("timeout", 513, 384);
      chk("timeout_pulses", n_pulses - p0, 1);

      // reset mid-packet
      do_reset();
      cyc(1'b1, 8'h09);
      cyc(1'b1, 8'h10);
      cyc(1'b0, 8'h00);
      do_reset();
      pkt3(8'h09, 8'h10, 8'h20);
      expect_now("after_rst", 528, 352);

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         bit [7:0] d;
         bit v;
         d = 8'($urandom);
         if ($urandom_range(0, 3) != 0) d[3] = 1'b1;
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 60) == 0) begin
            for (int k = 0; k < TO + $urandom_range(0, 3) - 2; k++) cyc(1'b0, 8'h00);
         end else if ($urandom_range(0, 400) == 0) begin
            do_reset();
         end else begin
            cyc(v, d);
         end
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
